// File: rtl/alu_if.sv
// Operand/result bundle between an instruction sequencer and the ALU.
// The sequencer drives operands and opcode; the ALU returns registered result and PSW.
interface alu_if;
   logic [15:0] d_bus;
   logic [15:0] s_bus;
   logic [5:0]  alu_op;
   logic [15:0] psw_in;
   logic        psw_update;
   logic [15:0] alu_out;
   logic [15:0] alu_psw_out;

   modport master (
      output d_bus, s_bus, alu_op, psw_in, psw_update,
      input  alu_out, alu_psw_out
   );

   modport slave (
      input  d_bus, s_bus, alu_op, psw_in, psw_update,
      output alu_out, alu_psw_out
   );
endinterface

// File: rtl/alu.sv
// 16-bit ALU with byte/word modes, BCD add and PSW flag generation.
// Result and PSW are computed combinationally and registered once per clock.
module alu (
   input  logic  Clock,
   input  logic  reset_n,
   alu_if.slave  bus
);
   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_ADDC = 5'd1;
   localparam logic [4:0] OP_SUB  = 5'd2;
   localparam logic [4:0] OP_SUBC = 5'd3;
   localparam logic [4:0] OP_DADD = 5'd4;
   localparam logic [4:0] OP_CMP  = 5'd5;
   localparam logic [4:0] OP_XOR  = 5'd6;
   localparam logic [4:0] OP_AND  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8;
   localparam logic [4:0] OP_BIT  = 5'd9;
   localparam logic [4:0] OP_BIC  = 5'd10;
   localparam logic [4:0] OP_BIS  = 5'd11;
   localparam logic [4:0] OP_MOV  = 5'd12;
   localparam logic [4:0] OP_SRA  = 5'd13;
   localparam logic [4:0] OP_RRC  = 5'd14;
   localparam logic [4:0] OP_SWPB = 5'd15;
   localparam logic [4:0] OP_SXT  = 5'd16;

   localparam logic [15:0] PSW_RESET = 16'h60E0;

   logic [15:0] d;
   logic [15:0] s;
   logic [4:0]  op;
   logic        byte_mode;
   logic        c_in;

   assign d         = bus.d_bus;
   assign s         = bus.s_bus;
   assign op        = bus.alu_op[4:0];
   assign byte_mode = bus.alu_op[5];
   assign c_in      = bus.psw_in[0];

   // Shared binary adder: subtraction is D + ~S + cin
   logic        is_sub;
   logic        add_cin;
   logic [15:0] b_opnd;
   logic [16:0] sum_w;
   logic [8:0]  sum_b;
   logic        a_msb;
   logic        b_msb;
   logic        r_msb;
   logic        arith_v;

   always_comb begin
      is_sub  = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
      b_opnd  = is_sub ? ~s : s;
      if (op == OP_ADD)
         add_cin = 1'b0;
      else if ((op == OP_ADDC) || (op == OP_SUBC))
         add_cin = c_in;
      else
         add_cin = 1'b1;
      sum_w   = {1'b0, d} + {1'b0, b_opnd} + {16'b0, add_cin};
      sum_b   = {1'b0, d[7:0]} + {1'b0, b_opnd[7:0]} + {8'b0, add_cin};
      a_msb   = byte_mode ? d[7]      : d[15];
      b_msb   = byte_mode ? b_opnd[7] : b_opnd[15];
      r_msb   = byte_mode ? sum_b[7]  : sum_w[15];
      arith_v = (a_msb == b_msb) && (r_msb != a_msb);
   end

   // Decimal adder: ripple of per-nibble BCD digit adders
   logic [4:0]  bcd_c;
   logic [15:0] bcd_sum;

   assign bcd_c[0] = c_in;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
         logic [4:0] raw;
         logic       over;
         assign raw   = {1'b0, d[gi*4 +: 4]} + {1'b0, s[gi*4 +: 4]} + {4'b0, bcd_c[gi]};
         assign over  = (raw > 5'd9);
         assign bcd_c[gi+1]       = over;
         assign bcd_sum[gi*4 +: 4] = over ? (raw[3:0] - 4'd10) : raw[3:0];
      end
   endgenerate

   logic [15:0] calc;
   logic [15:0] result;
   logic        full_word;
   logic        upd_zn;
   logic        new_c;
   logic        new_v;
   logic        new_z;
   logic        new_n;
   logic        byte_active;
   logic [15:0] psw_next;

   always_comb begin
      calc      = d;
      result    = d;
      full_word = 1'b0;
      upd_zn    = 1'b0;
      new_c     = c_in;
      new_v     = bus.psw_in[4];
      case (op)
         OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
            calc   = byte_mode ? {d[15:8], sum_b[7:0]} : sum_w[15:0];
            result = (op == OP_CMP) ? d : calc;
            new_c  = byte_mode ? sum_b[8] : sum_w[16];
            new_v  = arith_v;
            upd_zn = 1'b1;
         end
         OP_DADD: begin
            calc   = byte_mode ? {d[15:8], bcd_sum[7:0]} : bcd_sum;
            result = calc;
            new_c  = byte_mode ? bcd_c[2] : bcd_c[4];
            upd_zn = 1'b1;
         end
         OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
            case (op)
               OP_XOR:         calc = d ^ s;
               OP_AND, OP_BIT: calc = d & s;
               OP_BIC:         calc = d & ~s;
               default:        calc = d | s;
            endcase
            result = (op == OP_BIT) ? d : calc;
            new_v  = 1'b0;
            upd_zn = 1'b1;
         end
         OP_MOV: begin
            calc   = s;
            result = s;
         end
         OP_SRA: begin
            calc   = byte_mode ? {d[15:8], d[7], d[7:1]} : {d[15], d[15:1]};
            result = calc;
            new_c  = d[0];
            upd_zn = 1'b1;
         end
         OP_RRC: begin
            calc   = byte_mode ? {d[15:8], c_in, d[7:1]} : {c_in, d[15:1]};
            result = calc;
            new_c  = d[0];
            upd_zn = 1'b1;
         end
         OP_SWPB: begin
            calc      = {d[7:0], d[15:8]};
            result    = calc;
            full_word = 1'b1;
            upd_zn    = 1'b1;
         end
         OP_SXT: begin
            calc      = {{8{d[7]}}, d[7:0]};
            result    = calc;
            full_word = 1'b1;
            upd_zn    = 1'b1;
         end
         default: begin
            calc   = d;
            result = d;
         end
      endcase

      // Byte ops keep the destination's high byte untouched
      if (byte_mode && (op <= OP_RRC))
         result = {d[15:8], result[7:0]};

      byte_active = byte_mode && !full_word;
      if (upd_zn) begin
         new_z = byte_active ? (calc[7:0] == 8'h00) : (calc == 16'h0000);
         new_n = byte_active ? calc[7] : calc[15];
      end else begin
         new_z = bus.psw_in[1];
         new_n = bus.psw_in[2];
      end

      psw_next = bus.psw_in;
      if (bus.psw_update) begin
         psw_next[0] = new_c;
         psw_next[1] = new_z;
         psw_next[2] = new_n;
         psw_next[4] = new_v;
      end
   end

   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.alu_out     <= 16'h0000;
         bus.alu_psw_out <= PSW_RESET;
      end else begin
         bus.alu_out     <= result;
         bus.alu_psw_out <= psw_next;
      end
   end
endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for the ALU: each op's expectation is queued when driven
// and popped one clock later, with spec vectors checked against literal constants.
module tb_alu;
   logic Clock;
   logic reset_n;
   int   n_cmp;
   int   n_err;
   logic [31:0] sb[$];

   alu_if bus ();

   alu dut (
      .Clock   (Clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Independent reference: integer arithmetic over the active width
   function automatic logic [31:0] model(input logic [15:0] d, input logic [15:0] s,
                                         input logic [5:0] aop, input logic [15:0] psw,
                                         input logic upd);
      logic [31:0] mask, dv, sv, bb, r, t;
      logic [15:0] res, pswo;
      logic        c, z, n, v, zn, cc, bm, full;
      int          op, w;
      bm   = aop[5];
      op   = int'(aop[4:0]);
      full = (op == 15) || (op == 16);
      w    = (bm && !full) ? 8 : 16;
      mask = (32'd1 << w) - 32'd1;
      dv   = {16'b0, d} & mask;
      sv   = {16'b0, s} & mask;
      c = psw[0]; z = psw[1]; n = psw[2]; v = psw[4]; zn = 1'b0;
      r = dv;
      case (op)
         0, 1, 2, 3, 5: begin
            bb = (op == 2 || op == 3 || op == 5) ? (~sv & mask) : sv;
            if (op == 0)                 t = 0;
            else if (op == 1 || op == 3) t = {31'b0, c};
            else                         t = 1;
            r  = dv + bb + t;
            c  = r[w];
            r  = r & mask;
            v  = (dv[w-1] == bb[w-1]) && (r[w-1] != dv[w-1]);
            zn = 1'b1;
         end
         4: begin
            r = 0; cc = c;
            for (int k = 0; k < w / 4; k++) begin
               t = ((dv >> (4 * k)) & 32'hF) + ((sv >> (4 * k)) & 32'hF) + {31'b0, cc};
               if (t > 9) begin t = t - 10; cc = 1'b1; end
               else cc = 1'b0;
               r = r | (t << (4 * k));
            end
            c  = cc;
            zn = 1'b1;
         end
         6:     begin r = dv ^ sv;         v = 1'b0; zn = 1'b1; end
         7, 9:  begin r = dv & sv;         v = 1'b0; zn = 1'b1; end
         8, 11: begin r = dv | sv;         v = 1'b0; zn = 1'b1; end
         10:    begin r = dv & ~sv & mask; v = 1'b0; zn = 1'b1; end
         12:    r = sv;
         13: begin
            r = (dv >> 1) | ({31'b0, dv[w-1]} << (w - 1));
            c = dv[0]; zn = 1'b1;
         end
         14: begin
            r = (dv >> 1) | ({31'b0, c} << (w - 1));
            c = dv[0]; zn = 1'b1;
         end
         15: begin r = {16'b0, d[7:0], d[15:8]};    zn = 1'b1; end
         16: begin r = {16'b0, {8{d[7]}}, d[7:0]};  zn = 1'b1; end
         default: r = {16'b0, d};
      endcase
      if (zn) begin
         z = ((r & mask) == 0);
         n = r[w-1];
      end
      if (op == 5 || op == 9 || op > 16) res = d;
      else if (w == 8)                    res = {d[15:8], r[7:0]};
      else                                res = r[15:0];
      pswo = psw;
      if (upd) begin
         pswo[0] = c; pswo[1] = z; pswo[2] = n; pswo[4] = v;
      end
      return {res, pswo};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] d, input logic [15:0] s,
                         input logic [5:0] aop, input logic [15:0] psw, input logic upd,
                         input logic use_exp, input logic [31:0] exp_val);
      logic [31:0] e;
      @(negedge Clock);
      bus.d_bus      = d;
      bus.s_bus      = s;
      bus.alu_op     = aop;
      bus.psw_in     = psw;
      bus.psw_update = upd;
      sb.push_back(use_exp ? exp_val : model(d, s, aop, psw, upd));
      @(posedge Clock);
      #1;
      e = sb.pop_front();
      check({tag, ".out"}, bus.alu_out, e[31:16]);
      check({tag, ".psw"}, bus.alu_psw_out, e[15:0]);
      $display("%-10s op=%h d=%h s=%h psw=%h upd=%b -> out=%h psw=%h (exp %h/%h)",
               tag, aop, d, s, psw, upd, bus.alu_out, bus.alu_psw_out, e[31:16], e[15:0]);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      bus.d_bus      = 16'h0;
      bus.s_bus      = 16'h0;
      bus.alu_op     = 6'h0;
      bus.psw_in     = 16'h0;
      bus.psw_update = 1'b0;
      reset_n        = 1'b1;
      #1 reset_n = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      check("rst.out", bus.alu_out, 16'h0000);
      check("rst.psw", bus.alu_psw_out, 16'h60E0);
      $display("reset      out=%h psw=%h", bus.alu_out, bus.alu_psw_out);
      @(negedge Clock);
      reset_n = 1'b1;

      // Literal vectors
      run_op("add_ovf",  16'h7FFF, 16'h0001, 6'h00, 16'h60E0, 1'b1, 1'b1, 32'h8000_60F4);
      run_op("subb_z",   16'h1234, 16'h0034, 6'h22, 16'h60E0, 1'b1, 1'b1, 32'h1200_60E3);
      run_op("dadd_w",   16'h0999, 16'h0001, 6'h04, 16'h60E0, 1'b1, 1'b1, 32'h1000_60E0);
      run_op("rrc_w",    16'h0001, 16'h0000, 6'h0E, 16'h60E1, 1'b1, 1'b1, 32'h8000_60E5);
      run_op("add_noupd",16'h1111, 16'h2222, 6'h00, 16'h60E3, 1'b0, 1'b1, 32'h3333_60E3);

      // Model-checked coverage of the remaining ops and byte boundaries
      run_op("addc_w",   16'hFFFF, 16'h0000, 6'h01, 16'h0001, 1'b1, 1'b0, 32'h0);
      run_op("addb_c",   16'hAB80, 16'h0080, 6'h20, 16'h0010, 1'b1, 1'b0, 32'h0);
      run_op("subc_w",   16'h0005, 16'h0007, 6'h03, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("sub_ovf",  16'h8000, 16'h0001, 6'h02, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("cmp_eq",   16'h4321, 16'h4321, 6'h05, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("daddb_c",  16'h7799, 16'h0001, 6'h24, 16'h60F1, 1'b1, 1'b0, 32'h0);
      run_op("dadd_top", 16'h9999, 16'h0001, 6'h04, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("xor_w",    16'hF0F0, 16'hFF00, 6'h06, 16'h60F1, 1'b1, 1'b0, 32'h0);
      run_op("and_b",    16'h12F0, 16'hFF0F, 6'h27, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("or_w",     16'h8000, 16'h0001, 6'h08, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("bit_w",    16'h00F0, 16'h000F, 6'h09, 16'h60F5, 1'b1, 1'b0, 32'h0);
      run_op("bic_w",    16'hFFFF, 16'h00FF, 6'h0A, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("bis_b",    16'hAA00, 16'h0081, 6'h2B, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("mov_w",    16'h1234, 16'hBEEF, 6'h0C, 16'h60F7, 1'b1, 1'b0, 32'h0);
      run_op("mov_b",    16'h1234, 16'hBEEF, 6'h2C, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("sra_w",    16'h8003, 16'h0000, 6'h0D, 16'h60F0, 1'b1, 1'b0, 32'h0);
      run_op("sra_b",    16'h5581, 16'h0000, 6'h2D, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("rrc_b",    16'hFF02, 16'h0000, 6'h2E, 16'h60E1, 1'b1, 1'b0, 32'h0);
      run_op("swpb_b",   16'h00A5, 16'h0000, 6'h2F, 16'h60E1, 1'b1, 1'b0, 32'h0);
      run_op("sxt_w",    16'h1280, 16'h0000, 6'h10, 16'h60E0, 1'b1, 1'b0, 32'h0);
      run_op("noop_17",  16'hCAFE, 16'h1111, 6'h11, 16'h60F7, 1'b1, 1'b0, 32'h0);
      run_op("noop_31b", 16'h0000, 16'h1111, 6'h3F, 16'h60E2, 1'b1, 1'b0, 32'h0);

      // Asynchronous reset mid-operation: pending result must be discarded
      @(negedge Clock);
      bus.d_bus      = 16'hFFFF;
      bus.s_bus      = 16'h0001;
      bus.alu_op     = 6'h00;
      bus.psw_in     = 16'h60FF;
      bus.psw_update = 1'b1;
      sb.push_back(model(16'hFFFF, 16'h0001, 6'h00, 16'h60FF, 1'b1));
      #2 reset_n = 1'b0;
      #1;
      check("arst.out", bus.alu_out, 16'h0000);
      check("arst.psw", bus.alu_psw_out, 16'h60E0);
      $display("async_rst  out=%h psw=%h", bus.alu_out, bus.alu_psw_out);
      @(posedge Clock);
      #1;
      check("hold.out", bus.alu_out, 16'h0000);
      check("hold.psw", bus.alu_psw_out, 16'h60E0);
      $display("rst_hold   out=%h psw=%h", bus.alu_out, bus.alu_psw_out);
      sb.delete();
      @(negedge Clock);
      reset_n = 1'b1;
      run_op("post_rst", 16'h0002, 16'h0003, 6'h00, 16'h60E0, 1'b1, 1'b1, 32'h0005_60E0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
